// File: rtl/minmax_tracker4_pkg.sv
// Shared types for the per-frame min/max tracker: FSM encodings and sample width.
package minmax_tracker4_pkg;
   localparam int DATA_W = 4;

   // 2'd3 is unused and steers back to IDLE in the tracker's next-state logic.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/comp4bit_beh.sv
// 4-bit two's-complement magnitude comparator; purely combinational.
module comp4bit_beh (
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       AgtB,
   output logic       AeqB,
   output logic       AltB
);
   always_comb begin
      AgtB = ($signed(A) >  $signed(B));
      AeqB = (A == B);
      AltB = ($signed(A) <  $signed(B));
   end
endmodule

// File: rtl/minmax_tracker4.sv
// Per-frame running max/min/count of signed 4-bit samples; result valid 1 cycle after last accept.
// Input stalls (in_ready=0) while a result is pending; the result is held until out_ready.
module minmax_tracker4
   import minmax_tracker4_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_max,
   output logic [DATA_W-1:0] out_min,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] r_min;
   logic [CNT_W-1:0]  r_count;
   logic              r_ovf;

   logic w_accept;
   logic w_take;
   logic w_max_gt;
   logic w_min_lt;
   logic w_max_eq_unused;
   logic w_max_lt_unused;
   logic w_min_gt_unused;
   logic w_min_eq_unused;

   assign w_accept = in_valid & in_ready;
   assign w_take   = out_valid & out_ready;

   comp4bit_beh u_cmp_max (
      .A    (in_data),
      .B    (r_max),
      .AgtB (w_max_gt),
      .AeqB (w_max_eq_unused),
      .AltB (w_max_lt_unused)
   );

   comp4bit_beh u_cmp_min (
      .A    (in_data),
      .B    (r_min),
      .AgtB (w_min_gt_unused),
      .AeqB (w_min_eq_unused),
      .AltB (w_min_lt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ACC: begin
            if (w_accept && in_last) w_next = DONE;
         end
         DONE: begin
            if (w_take) w_next = IDLE;
         end
         default: begin
            if (w_accept) w_next = in_last ? DONE : ACC;
            else          w_next = IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready  = (r_state != DONE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_max   <= '0;
         r_min   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ACC: begin
               if (w_accept) begin
                  if (w_max_gt) r_max <= in_data;
                  if (w_min_lt) r_min <= in_data;
                  // Saturate rather than wrap; ovf records the lost increments.
                  if (r_count == CNT_MAX) r_ovf   <= 1'b1;
                  else                    r_count <= r_count + CNT_W'(1);
               end
            end
            DONE: begin
               if (w_take) begin
                  r_count <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            default: begin
               if (w_accept) begin
                  r_max   <= in_data;
                  r_min   <= in_data;
                  r_count <= CNT_W'(1);
                  r_ovf   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign out_max   = r_max;
   assign out_min   = r_min;
   assign out_count = r_count;
   assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_minmax_tracker4.sv
// Scoreboard bench for minmax_tracker4: one instance at CNT_W=8, one at CNT_W=3 for saturation.
module tb_minmax_tracker4;
   typedef struct packed {
      logic [3:0] mx;
      logic [3:0] mn;
      logic [7:0] cnt;
      logic       ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid8 = 1'b0, in_last8 = 1'b0, out_ready8 = 1'b0;
   logic [3:0] in_data8 = '0;
   logic       in_ready8, out_valid8, out_ovf8;
   logic [3:0] out_max8, out_min8;
   logic [7:0] out_count8;

   logic       in_valid3 = 1'b0, in_last3 = 1'b0, out_ready3 = 1'b0;
   logic [3:0] in_data3 = '0;
   logic       in_ready3, out_valid3, out_ovf3;
   logic [3:0] out_max3, out_min3;
   logic [2:0] out_count3;

   int   n_cmp = 0;
   int   n_err = 0;
   res_t exp_q[$];

   minmax_tracker4 #(.CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_last(in_last8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .out_max(out_max8), .out_min(out_min8), .out_count(out_count8), .out_ovf(out_ovf8)
   );

   minmax_tracker4 #(.CNT_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_last(in_last3),
      .out_valid(out_valid3), .out_ready(out_ready3),
      .out_max(out_max3), .out_min(out_min3), .out_count(out_count3), .out_ovf(out_ovf3)
   );

   function automatic res_t mk(input int mx, input int mn, input int cnt, input bit ovf);
      res_t r;
      r.mx  = 4'(mx);
      r.mn  = 4'(mn);
      r.cnt = 8'(cnt);
      r.ovf = ovf;
      return r;
   endfunction

   function automatic res_t obs8();
      return {out_max8, out_min8, out_count8, out_ovf8};
   endfunction

   function automatic res_t obs3();
      return {out_max3, out_min3, 5'b0, out_count3, out_ovf3};
   endfunction

   // Entered and left just after a rising edge; bounded wait for in_ready.
   task automatic send8(input int d, input bit last, output bit ok);
      in_valid8 = 1'b1; in_data8 = 4'(d); in_last8 = last; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready8 === 1'b1) begin
            @(posedge clk); #1; ok = 1'b1;
            break;
         end
      end
      in_valid8 = 1'b0; in_last8 = 1'b0;
   endtask

   task automatic send3(input int d, input bit last, output bit ok);
      in_valid3 = 1'b1; in_data3 = 4'(d); in_last3 = last; ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready3 === 1'b1) begin
            @(posedge clk); #1; ok = 1'b1;
            break;
         end
      end
      in_valid3 = 1'b0; in_last3 = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         n_err++; $display("FAIL reset_hs8: rdy=%b vld=%b want rdy=1 vld=0", in_ready8, out_valid8);
      end
      n_cmp++;
      if (obs8() !== res_t'(0)) begin
         n_err++; $display("FAIL reset_out8: got %h want %h", obs8(), res_t'(0));
      end
      n_cmp++;
      if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || obs3() !== res_t'(0)) begin
         n_err++; $display("FAIL reset_dut3: rdy=%b vld=%b out=%h want 1/0/0", in_ready3, out_valid3, obs3());
      end
      @(posedge clk); #2; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ok, all_ok;
      res_t e;
      all_ok = 1'b1; out_ready8 = 1'b1;
      send8(3, 0, ok);  all_ok &= ok;
      send8(-2, 0, ok); all_ok &= ok;
      send8(7, 0, ok);  all_ok &= ok;
      exp_q.push_back(mk(7, -8, 4, 0));
      send8(-8, 1, ok); all_ok &= ok;
      n_cmp++;
      if (!all_ok) begin n_err++; $display("FAIL basic_accept: got stalled want accepted"); end
      @(negedge clk);
      n_cmp++;
      if (out_valid8 !== 1'b1) begin n_err++; $display("FAIL basic_latency: out_valid=%b want 1", out_valid8); end
      e = exp_q.pop_front();
      n_cmp++;
      if (obs8() !== e) begin n_err++; $display("FAIL basic_result: got %h want %h", obs8(), e); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
         n_err++; $display("FAIL basic_idle: vld=%b rdy=%b want 0/1", out_valid8, in_ready8);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_and_ties();
      bit ok, all_ok;
      res_t e;
      all_ok = 1'b1; out_ready8 = 1'b1;
      exp_q.push_back(mk(-5, -5, 1, 0));
      send8(-5, 1, ok); all_ok &= ok;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid8 !== 1'b1 || obs8() !== e) begin
         n_err++; $display("FAIL single: vld=%b got %h want vld=1 %h", out_valid8, obs8(), e);
      end
      @(posedge clk); #1;
      send8(0, 0, ok); all_ok &= ok;
      send8(0, 0, ok); all_ok &= ok;
      exp_q.push_back(mk(0, 0, 3, 0));
      send8(0, 1, ok); all_ok &= ok;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid8 !== 1'b1 || obs8() !== e || !all_ok) begin
         n_err++; $display("FAIL ties: vld=%b ok=%b got %h want vld=1 ok=1 %h", out_valid8, all_ok, obs8(), e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bit ok, all_ok, stable;
      res_t e;
      all_ok = 1'b1; stable = 1'b1; out_ready8 = 1'b0;
      send8(1, 0, ok); all_ok &= ok;
      exp_q.push_back(mk(2, 1, 2, 0));
      send8(2, 1, ok); all_ok &= ok;
      in_valid8 = 1'b1; in_data8 = 4'(5); in_last8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || obs8() !== exp_q[0]) stable = 1'b0;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (!stable) begin n_err++; $display("FAIL bp_hold: vld=%b rdy=%b got %h want 1/0 %h", out_valid8, in_ready8, obs8(), exp_q[0]); end
      out_ready8 = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid8 !== 1'b1 || obs8() !== e || !all_ok) begin
         n_err++; $display("FAIL bp_take: vld=%b got %h want vld=1 %h", out_valid8, obs8(), e);
      end
      exp_q.push_back(mk(5, 5, 1, 0));
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         n_err++; $display("FAIL bp_reopen: rdy=%b vld=%b want 1/0", in_ready8, out_valid8);
      end
      @(posedge clk); #1;
      in_valid8 = 1'b0; in_last8 = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid8 !== 1'b1 || obs8() !== e) begin
         n_err++; $display("FAIL bp_held_sample: vld=%b got %h want vld=1 %h", out_valid8, obs8(), e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      bit ok, all_ok;
      res_t e;
      all_ok = 1'b1; out_ready3 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) exp_q.push_back(mk(1, 1, 7, 1));
         send3(1, (i == 8), ok); all_ok &= ok;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid3 !== 1'b1 || obs3() !== e || !all_ok) begin
         n_err++; $display("FAIL sat_ovf: vld=%b got %h want vld=1 %h", out_valid3, obs3(), e);
      end
      @(posedge clk); #1;
      send3(2, 0, ok); all_ok &= ok;
      exp_q.push_back(mk(2, -1, 2, 0));
      send3(-1, 1, ok); all_ok &= ok;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid3 !== 1'b1 || obs3() !== e || !all_ok) begin
         n_err++; $display("FAIL sat_clear: vld=%b got %h want vld=1 %h", out_valid3, obs3(), e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_gapped();
      bit ok, all_ok, held;
      res_t e;
      all_ok = 1'b1; held = 1'b1; out_ready8 = 1'b1;
      send8(-1, 0, ok); all_ok &= ok;
      // Gap cycles carry a stray in_last and data that must be ignored.
      in_valid8 = 1'b0; in_data8 = 4'(7); in_last8 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (out_valid8 !== 1'b0 || out_count8 !== 8'd1 || out_max8 !== 4'hF || out_min8 !== 4'hF) held = 1'b0;
         @(posedge clk); #1;
      end
      in_last8 = 1'b0;
      n_cmp++;
      if (!held) begin n_err++; $display("FAIL gap_hold: vld=%b cnt=%0d max=%h want 0/1/f", out_valid8, out_count8, out_max8); end
      send8(6, 0, ok); all_ok &= ok;
      exp_q.push_back(mk(6, -3, 3, 0));
      send8(-3, 1, ok); all_ok &= ok;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid8 !== 1'b1 || obs8() !== e || !all_ok) begin
         n_err++; $display("FAIL gap_result: vld=%b got %h want vld=1 %h", out_valid8, obs8(), e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok, all_ok;
      res_t e;
      all_ok = 1'b1; out_ready8 = 1'b1;
      send8(3, 0, ok); all_ok &= ok;
      send8(5, 0, ok); all_ok &= ok;
      #2; rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs8() !== res_t'(0) || in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         n_err++; $display("FAIL rst_async: got %h rdy=%b vld=%b want 0 rdy=1 vld=0", obs8(), in_ready8, out_valid8);
      end
      @(posedge clk); #3; rst_n = 1'b1;
      @(posedge clk); #1;
      send8(4, 0, ok); all_ok &= ok;
      exp_q.push_back(mk(4, -4, 2, 0));
      send8(-4, 1, ok); all_ok &= ok;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid8 !== 1'b1 || obs8() !== e || !all_ok) begin
         n_err++; $display("FAIL rst_after: vld=%b got %h want vld=1 %h", out_valid8, obs8(), e);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single_and_ties();
      test_backpressure();
      test_saturate();
      test_gapped();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/minmax_tracker4.md
Name: minmax_tracker4

Overview:
- Downstream consumer of the team's 4-bit signed magnitude comparator (comp4bit_beh).
- Accepts a framed stream of 4-bit two's-complement samples over a valid/ready handshake.
- Tracks the running maximum, running minimum and sample count per frame.
- Presents the frame result on a valid/ready output port until it is taken.

Parameters:
CNT_W, 8, width of the per-frame sample counter (minimum 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  sample present on in_data
in_ready  output  1  block can accept a sample this cycle
in_data  input  4  signed sample, range -8..7
in_last  input  1  qualifies in_data as the final sample of the frame
out_valid  output  1  frame result available
out_ready  input  1  consumer takes the result this cycle
out_max  output  4  largest signed sample of the frame
out_min  output  4  smallest signed sample of the frame
out_count  output  CNT_W  number of samples in the frame, saturating
out_ovf  output  1  sticky flag: count saturated during the frame

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous and active-low.
- Reset:
  - state=IDLE.
  - max_q, min_q, count_q and ovf_q are all 0.
  - out_valid=0, in_ready=1 (combinational from state).
  - out_max, out_min, out_count and out_ovf are all 0.
- Transfers:
  - Input accept = in_valid & in_ready.
  - Output take = out_valid & out_ready.
- in_ready = (state != DONE). out_valid = (state == DONE). Both are pure functions of state, with no combinational path from in_valid or out_ready.
- Ordering: two's-complement signed. Two comparator instances, with no internal compare logic duplicated:
  - in_data vs max_q. Update max when AgtB=1.
  - in_data vs min_q. Update min when AltB=1.
  - Ties (AeqB=1) leave the register unchanged.
- State IDLE (no sample yet in frame). On accept:
  - max_q=min_q=in_data, count_q=1, ovf_q=0.
  - in_last=1 goes to DONE; otherwise goes to ACC.
- State ACC. On accept:
  - Conditional max/min update as above.
  - count_q+1, saturating at 2^CNT_W-1. If the increment is attempted at saturation, ovf_q is set and held.
  - in_last=1 goes to DONE. With no accept, all registers hold.
- State DONE:
  - out_max/out_min/out_count/out_ovf are driven from registers and held stable while out_ready=0.
  - On take, go to IDLE and clear count_q and ovf_q to 0. max_q/min_q may hold stale values but are overwritten by the first sample.
- Latency: the result is valid on the clock edge after the last sample is accepted (1 cycle).
- Throughput: one sample per cycle. Minimum frame turnaround is one DONE cycle, since in_ready=0 while in DONE.
- Simultaneous events:
  - in_valid in DONE is not accepted; upstream must hold the sample.
  - out_ready outside DONE is ignored.
  - in_last with in_valid=0 is ignored.
- Boundaries:
  - Single-sample frame gives max=min=sample, count=1.
  - A -8 sample is never a new max unless it is first. A 7 sample is never a new min unless it is first.
- Reset mid-operation: the partial frame or pending result is discarded. Registers go to reset values immediately, without waiting for a clock.
- Output registers: outputs update only on state/register changes, so they are glitch-free registered values.

Decomposition:
- Shared package/include:
  - State encodings IDLE=2'd0, ACC=2'd1, DONE=2'd2 (2'd3 recovers to IDLE).
  - DATA_W=4 constant.
- Sub-module: reuse comp4bit_beh (two instances). No new sub-module is required.
- The FSM, registers and counter live in the top.

Test Plan:
- Frame 3,-2,7,-8 (last on -8), out_ready=1 → out_valid one cycle after last accept; max=7, min=-8 (4'b1000), count=4, ovf=0; back to IDLE the next cycle.
- Single sample -5 with in_last → max=min=-5 (4'b1011), count=1. Then frame 0,0,0 → max=min=0, count=3, demonstrating the ties/no-update path.
- Backpressure: frame 1,2 with out_ready=0 for 5 cycles →
  - out_valid held 5 cycles with stable outputs.
  - in_ready=0 throughout; a new in_valid sample is held and not accepted.
  - It is accepted the cycle after the take.
- CNT_W=3, 9-sample frame of 1s (last on 9th) → count=7, ovf=1. The next frame has ovf=0.
- Gapped input: in_valid toggling 1,0,0,1,1 with samples -1,6,-3 → registers hold during gaps; max=6, min=-3, count=3.
- Assert rst_n mid-frame after 2 samples, asynchronously between edges → outputs zero immediately, in_ready=1. A following frame 4,-4 gives max=4, min=-4, count=2.
